// File: rtl/artyz7_led_pattern.sv
`timescale 1ns/1ps
// artyz7_led_pattern: push-button driven LED pattern generator.
// A debounced button press steps the mode OFF -> COUNT -> SHIFT -> BLINK -> OFF;
// a free-running prescaler produces the pattern tick.
// Optional feature macro: ARTYZ7_LED_PATTERN_DEBOUNCE_EN enables the
// debounce counter on the synchronized button level.
module artyz7_led_pattern #(
  parameter int num_leds        = 4,
  parameter int tick_period     = 12500000,
  parameter int debounce_cycles = 1250000
) (
  input  logic                ext_clk,
  input  logic                ext_reset_n,
  input  logic                button,
  input  logic                enable,
  output logic [0:num_leds-1] led,
  output logic [1:0]          mode,
  output logic                tick
);

  localparam int              PW        = $clog2(tick_period);
  localparam logic [PW-1:0]   TICK_LAST = PW'(tick_period - 1);

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_COUNT = 2'd1,
    M_SHIFT = 2'd2,
    M_BLINK = 2'd3
  } mode_e;

  // Reject parameter values outside the supported range at elaboration.
  if (num_leds < 1 || num_leds > 32 || tick_period < 2 || debounce_cycles < 1) begin : g_bad_params
    $error("artyz7_led_pattern: illegal parameter value");
  end

  logic                sync1_q, sync2_q;
  logic                db_level;
  logic                db_prev_q;
  logic                press;
  logic [PW-1:0]       presc_q;
  logic                tick_q;
  mode_e               mode_q;
  logic [0:num_leds-1] pattern_q;

  // Next mode in the fixed press cycle.
  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    n = M_OFF;
    case (m)
      M_OFF:   n = M_COUNT;
      M_COUNT: n = M_SHIFT;
      M_SHIFT: n = M_BLINK;
      default: n = M_OFF;
    endcase
    return n;
  endfunction

  // Pattern loaded on entry to a mode; index 0 is the leftmost/MSB LED.
  function automatic logic [0:num_leds-1] init_pattern(input mode_e m);
    logic [0:num_leds-1] v;
    v = '0;
    case (m)
      M_SHIFT: v[0] = 1'b1;
      M_BLINK: v = '1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Pattern advance applied once per tick.
  function automatic logic [0:num_leds-1] step_pattern(input mode_e m,
                                                       input logic [0:num_leds-1] p);
    logic [0:num_leds-1] v;
    v = '0;
    case (m)
      M_COUNT: v = p + num_leds'(1);
      M_SHIFT: v = (p >> 1) | (p << (num_leds - 1));
      M_BLINK: v = ~p;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Two-flop synchronizer for the asynchronous push-button.
  always_ff @(posedge ext_clk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

`ifdef ARTYZ7_LED_PATTERN_DEBOUNCE_EN
  localparam int            DW      = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(debounce_cycles - 1);

  logic          db_level_q;
  logic [DW-1:0] db_cnt_q;

  // Accept a new level only after it disagrees for debounce_cycles cycles in a row.
  always_ff @(posedge ext_clk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
    end else if (sync2_q == db_level_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_level_q <= sync2_q;
      db_cnt_q   <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DW'(1);
    end
  end

  assign db_level = db_level_q;
`else
  assign db_level = sync2_q;
`endif

  // Remember the previous debounced level for rising-edge detection.
  always_ff @(posedge ext_clk or negedge ext_reset_n) begin
    if (!ext_reset_n) db_prev_q <= 1'b0;
    else              db_prev_q <= db_level;
  end

  assign press = db_level & ~db_prev_q;

  // Prescaler: wraps at tick_period-1 while enabled and flags one tick cycle.
  always_ff @(posedge ext_clk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (enable) begin
        if (presc_q == TICK_LAST) begin
          presc_q <= '0;
          tick_q  <= 1'b1;
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
    end
  end

  // Mode FSM and pattern register; a press outranks a coincident tick.
  always_ff @(posedge ext_clk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      mode_q    <= M_OFF;
      pattern_q <= '0;
    end else if (press) begin
      mode_q    <= next_mode(mode_q);
      pattern_q <= init_pattern(next_mode(mode_q));
    end else if (tick_q) begin
      pattern_q <= step_pattern(mode_q, pattern_q);
    end
  end

  assign led  = pattern_q;
  assign mode = mode_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_artyz7_led_pattern.sv
`timescale 1ns/1ps
// Bench for artyz7_led_pattern with num_leds=4, tick_period=4, debounce_cycles=8.
module tb_artyz7_led_pattern;

  localparam int N   = 4;
  localparam int TP  = 4;
  localparam int DBC = 8;
`ifdef ARTYZ7_LED_PATTERN_DEBOUNCE_EN
  localparam int LAT = 3 + DBC;
`else
  localparam int LAT = 3;
`endif
  // Press-into-tick alignment: start from led = 5-K, raise button D_OFF cycles later.
  localparam int K     = (LAT <= 4) ? 0 : (LAT - 4 + 3) / 4;
  localparam int D_OFF = 4 * K + 4 - LAT;
  localparam int TARGET = 5 - K;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         button = 1'b0;
  logic         enable = 1'b0;
  logic [0:N-1] led;
  logic [1:0]   mode;
  logic         tick;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic en;
    logic exp_tick;
  } tvec_t;

  tvec_t tv [26];
  int    cnt_exp [17];
  int    shift_exp [4];

  always #5 clk = ~clk;

  artyz7_led_pattern #(
    .num_leds(N),
    .tick_period(TP),
    .debounce_cycles(DBC)
  ) dut (
    .ext_clk(clk),
    .ext_reset_n(rst_n),
    .button(button),
    .enable(enable),
    .led(led),
    .mode(mode),
    .tick(tick)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for the tick pulse, confirm led holds, then confirm the update.
  task automatic tick_step(input string name, input int prev_led, input int exp_led);
    int waited;
    waited = 0;
    while (tick !== 1'b1 && waited < 4 * TP + 2) begin
      @(negedge clk);
      waited++;
    end
    check({name, " tick"}, int'(tick === 1'b1), 1);
    check({name, " hold"}, int'(led), prev_led);
    @(negedge clk);
    check({name, " led"}, int'(led), exp_led);
  endtask

  // One button press: checks exact latency of the mode change and the loaded pattern.
  task automatic press(input string name, input int old_mode, input int new_mode, input int new_led);
    cyc(LAT + 2);
    button = 1'b1;
    cyc(LAT - 1);
    check({name, " early"}, int'(mode), old_mode);
    cyc(1);
    check({name, " mode"}, int'(mode), new_mode);
    check({name, " led"}, int'(led), new_led);
    button = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int  prev;
    bit  seen6;

    tv = '{'{1'b1,1'b0}, '{1'b1,1'b0}, '{1'b1,1'b0}, '{1'b1,1'b1},
           '{1'b1,1'b0}, '{1'b1,1'b0}, '{1'b1,1'b0}, '{1'b1,1'b1},
           '{1'b1,1'b0}, '{1'b1,1'b0}, '{1'b1,1'b0}, '{1'b1,1'b1},
           '{1'b0,1'b0}, '{1'b0,1'b0}, '{1'b0,1'b0}, '{1'b0,1'b0}, '{1'b0,1'b0},
           '{1'b0,1'b0}, '{1'b0,1'b0}, '{1'b0,1'b0}, '{1'b0,1'b0}, '{1'b0,1'b0},
           '{1'b1,1'b0}, '{1'b1,1'b0}, '{1'b1,1'b0}, '{1'b1,1'b1}};
    cnt_exp   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1};
    shift_exp = '{4, 2, 1, 8};

    // Reset state
    cyc(3);
    check("reset led", int'(led), 0);
    check("reset mode", int'(mode), 0);
    check("reset tick", int'(tick), 0);

    // Prescaler phase and enable gating
    rst_n = 1'b1;
    for (int i = 0; i < 26; i++) begin
      enable = tv[i].en;
      @(negedge clk);
      check($sformatf("presc cyc%0d", i + 1), int'(tick), int'(tv[i].exp_tick));
    end
    check("presc mode", int'(mode), 0);
    check("presc led", int'(led), 0);

`ifdef ARTYZ7_LED_PATTERN_DEBOUNCE_EN
    // Short glitch must be rejected by the debouncer
    button = 1'b1;
    cyc(5);
    button = 1'b0;
    cyc(LAT + 10);
    check("glitch mode", int'(mode), 0);
`endif

    // COUNT: 17 ticks
    press("press1", 0, 1, 0);
    prev = 0;
    for (int i = 0; i < 17; i++) begin
      tick_step($sformatf("count%0d", i), prev, cnt_exp[i]);
      prev = cnt_exp[i];
    end

    // SHIFT: 4 ticks
    press("press2", 1, 2, 8);
    prev = 8;
    for (int i = 0; i < 4; i++) begin
      tick_step($sformatf("shift%0d", i), prev, shift_exp[i]);
      prev = shift_exp[i];
    end

    // BLINK, then back to OFF
    press("press3", 2, 3, 15);
    tick_step("blink", 15, 0);
    press("press4", 3, 0, 0);
    tick_step("off", 0, 0);

    // Press landing in the tick cycle while COUNT shows 0101
    press("press5", 0, 1, 0);
    for (int v = 1; v <= 16 + TARGET; v++)
      tick_step($sformatf("count2_%0d", v), (v - 1) & 15, v & 15);
    cyc(D_OFF);
    button = 1'b1;
    seen6 = 1'b0;
    for (int j = 1; j <= LAT; j++) begin
      @(negedge clk);
      if (int'(led) == 6) seen6 = 1'b1;
      if (j == LAT - 1) check("coincide tick", int'(tick), 1);
    end
    button = 1'b0;
    check("coincide mode", int'(mode), 2);
    check("coincide led", int'(led), 8);
    check("coincide no 0110", int'(seen6), 0);

    // Asynchronous reset mid-BLINK, button held through release
    press("press6", 2, 3, 15);
    cyc(2);
    #2;
    rst_n = 1'b0;
    button = 1'b1;
    #1;
    check("async rst led", int'(led), 0);
    check("async rst mode", int'(mode), 0);
    check("async rst tick", int'(tick), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(LAT - 1);
    check("held early mode", int'(mode), 0);
    cyc(1);
    check("held mode", int'(mode), 1);
    check("held led", int'(led), 0);
    cyc(30);
    check("held still", int'(mode), 1);
    button = 1'b0;
    cyc(LAT + 4);
    check("release no event", int'(mode), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
